// File: rtl/sa_pe_os.sv
// sa_pe_os: output-stationary systolic PE (signed MAC, operand forwarding, drain chain)
//   clk, rst_n               clock, asynchronous active-low reset
//   i_en                     global stall, 0 holds every register
//   i_a_vld/i_a -> o_a_vld/o_a   left operand in, forwarded right after 1 cycle
//   i_b_vld/i_b -> o_b_vld/o_b   top operand in, forwarded down after 1 cycle
//   i_clr, i_drain           accumulator clear, drain start pulse
//   i_res_vld/i_res -> o_res_vld/o_res   per-column result chain
//   o_busy, o_ovf, o_drain_err   pass-through active, sticky overflow, sticky drain-while-busy
//   SA_PE_SAT_EN             when defined, overflowing accumulation saturates instead of wrapping
module sa_pe_os #(
  parameter int DAT_WIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter int ROW       = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_a_vld,
  input  logic [DAT_WIDTH-1:0] i_a,
  input  logic                 i_b_vld,
  input  logic [DAT_WIDTH-1:0] i_b,
  output logic                 o_a_vld,
  output logic [DAT_WIDTH-1:0] o_a,
  output logic                 o_b_vld,
  output logic [DAT_WIDTH-1:0] o_b,
  input  logic                 i_clr,
  input  logic                 i_drain,
  input  logic                 i_res_vld,
  input  logic [ACC_WIDTH-1:0] i_res,
  output logic                 o_res_vld,
  output logic [ACC_WIDTH-1:0] o_res,
  output logic                 o_busy,
  output logic                 o_ovf,
  output logic                 o_drain_err
);
  localparam int CW  = (ROW > 0) ? $clog2(ROW + 1) : 1;
  localparam int MSB = ACC_WIDTH - 1;
  typedef enum logic {ACC, PASS} state_e;
  state_e                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d, res_q, res_d, prod_ext, sum, acc_next;
  logic signed [2*DAT_WIDTH-1:0] prod;
  logic                          mac, ovf_ev, ovf_q, ovf_d, res_vld_q, res_vld_d, err_q, err_d;
  logic                          a_vld_q, b_vld_q;
  logic [DAT_WIDTH-1:0]          a_q, b_q;
  assign mac      = i_a_vld & i_b_vld;
  assign prod     = (2*DAT_WIDTH)'($signed(i_a)) * (2*DAT_WIDTH)'($signed(i_b));
  assign prod_ext = ACC_WIDTH'(prod);
  assign sum      = acc_q + prod_ext;
  // overflow: both addends share a sign the wrapped sum does not
  assign ovf_ev   = mac & (acc_q[MSB] == prod_ext[MSB]) & (sum[MSB] != acc_q[MSB]);
`ifdef SA_PE_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  assign acc_next = !mac ? acc_q : ovf_ev ? (acc_q[MSB] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign acc_next = mac ? sum : acc_q;
`endif
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    res_vld_d = 1'b0;
    err_d     = err_q;
    acc_d     = i_clr ? '0 : acc_next;
    ovf_d     = i_clr ? 1'b0 : (ovf_q | ovf_ev);
    if (state_q == ACC) begin
      if (i_drain) begin
        res_d     = acc_next;
        res_vld_d = 1'b1;
        acc_d     = '0;
        ovf_d     = 1'b0;
        if (ROW > 0) begin
          state_d = PASS;
          cnt_d   = CW'(ROW);
        end
      end
    end else begin
      if (i_drain) err_d = 1'b1;
      if (i_res_vld) begin
        res_d     = i_res;
        res_vld_d = 1'b1;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ACC;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC;
      cnt_q     <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      a_vld_q   <= 1'b0;
      a_q       <= '0;
      b_vld_q   <= 1'b0;
      b_q       <= '0;
    end else if (i_en) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      a_vld_q   <= i_a_vld;
      a_q       <= i_a;
      b_vld_q   <= i_b_vld;
      b_q       <= i_b;
    end
  end
  assign o_a_vld     = a_vld_q;
  assign o_a         = a_q;
  assign o_b_vld     = b_vld_q;
  assign o_b         = b_q;
  assign o_res_vld   = res_vld_q;
  assign o_res       = res_q;
  assign o_busy      = (state_q == PASS);
  assign o_ovf       = ovf_q;
  assign o_drain_err = err_q;
endmodule

// File: tb/tb_sa_pe_os.sv
// tb_sa_pe_os: scoreboard bench for a ROW=0/ACC=20 PE and a ROW=2/ACC=16 PE
module tb_sa_pe_os;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        en = 1'b0, av = 1'b0, bv = 1'b0, clr = 1'b0, d0 = 1'b0, d2 = 1'b0, rv = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic [19:0] r0 = '0;
  logic [15:0] r2 = '0;
  logic        fav0, fbv0, rvo0, busy0, ovf0, err0;
  logic        fav2, fbv2, rvo2, busy2, ovf2, err2;
  logic [7:0]  fa0, fb0, fa2, fb2;
  logic [19:0] res0;
  logic [15:0] res2;
  int          n_tests = 0, n_fail = 0;
  longint      q0[$], q2[$];
  longint      m0 = 0, m2 = 0;
  bit          mov0 = 0, mov2 = 0, mbusy2 = 0, merr2 = 0;
  int          cnt2 = 0;
  bit          pav = 0, pbv = 0;
  logic [7:0]  pa = '0, pb = '0;
  always #5 clk = ~clk;
  sa_pe_os #(.DAT_WIDTH(8), .ACC_WIDTH(20), .ROW(0)) u0 (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_a_vld(av), .i_a(a), .i_b_vld(bv), .i_b(b),
    .o_a_vld(fav0), .o_a(fa0), .o_b_vld(fbv0), .o_b(fb0), .i_clr(clr), .i_drain(d0),
    .i_res_vld(rv), .i_res(r0), .o_res_vld(rvo0), .o_res(res0), .o_busy(busy0),
    .o_ovf(ovf0), .o_drain_err(err0));
  sa_pe_os #(.DAT_WIDTH(8), .ACC_WIDTH(16), .ROW(2)) u2 (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_a_vld(av), .i_a(a), .i_b_vld(bv), .i_b(b),
    .o_a_vld(fav2), .o_a(fa2), .o_b_vld(fbv2), .o_b(fb2), .i_clr(clr), .i_drain(d2),
    .i_res_vld(rv), .i_res(r2), .o_res_vld(rvo2), .o_res(res2), .o_busy(busy2),
    .o_ovf(ovf2), .o_drain_err(err2));
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint addw(input longint acc, input longint p, input int w, output bit ov);
    longint mx = (longint'(1) << (w - 1)) - 1;
    longint mn = -mx - 1;
    longint s = acc + p;
    ov = (s > mx) || (s < mn);
`ifdef SA_PE_SAT_EN
    if (s > mx) s = mx;
    else if (s < mn) s = mn;
`else
    if (s > mx) s -= longint'(1) << w;
    else if (s < mn) s += longint'(1) << w;
`endif
    return s;
  endfunction
  task automatic step(input bit iav, input int ia, input bit ibv, input int ib, input bit iclr = 0,
                      input bit id0 = 0, input bit id2 = 0, input bit irv = 0, input int ir = 0,
                      input bit ien = 1);
    longint p, n0, n2;
    bit o0, o2;
    av = iav; a = ia[7:0]; bv = ibv; b = ib[7:0]; clr = iclr;
    d0 = id0; d2 = id2; rv = irv; r0 = ir[19:0]; r2 = ir[15:0]; en = ien;
    @(posedge clk);
    if (ien) begin
      p = longint'(ia) * longint'(ib);
      o0 = 0; o2 = 0;
      if (iav && ibv) begin
        n0 = addw(m0, p, 20, o0);
        n2 = addw(m2, p, 16, o2);
      end else begin
        n0 = m0; n2 = m2;
      end
      if (id0) begin q0.push_back(n0); m0 = 0; mov0 = 0; end
      else if (iclr) begin m0 = 0; mov0 = 0; end
      else begin m0 = n0; mov0 |= o0; end
      if (!mbusy2 && id2) begin
        q2.push_back(n2); m2 = 0; mov2 = 0; mbusy2 = 1; cnt2 = 2;
      end else begin
        if (iclr) begin m2 = 0; mov2 = 0; end
        else begin m2 = n2; mov2 |= o2; end
        if (mbusy2) begin
          if (id2) merr2 = 1;
          if (irv) begin
            q2.push_back(longint'(ir));
            cnt2--;
            if (cnt2 == 0) mbusy2 = 0;
          end
        end
      end
      pav = iav; pa = ia[7:0]; pbv = ibv; pb = ib[7:0];
    end
    #1;
    chk("a_vld0", fav0, pav); chk("a0", fa0, pa); chk("b_vld0", fbv0, pbv); chk("b0", fb0, pb);
    chk("a2", fa2, pa); chk("b2", fb2, pb);
    chk("ovf0", ovf0, mov0); chk("ovf2", ovf2, mov2);
    chk("busy0", busy0, 0); chk("busy2", busy2, mbusy2);
    chk("err0", err0, 0); chk("err2", err2, merr2);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvo0) begin
        if (q0.size() == 0) chk("res0_extra", rvo0, 0);
        else chk("res0", $signed(res0), q0.pop_front());
      end else if (q0.size() != 0) chk("res0_missing", rvo0, 1);
      if (rvo2) begin
        if (q2.size() == 0) chk("res2_extra", rvo2, 0);
        else chk("res2", $signed(res2), q2.pop_front());
      end else if (q2.size() != 0) chk("res2_missing", rvo2, 1);
    end
  end
  task automatic beats2(input int x, input int y);
    step(0, 0, 0, 0, 0, 0, 0, 1, x);
    step(0, 0, 0, 0, 0, 0, 0, 1, y);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; av = 1'($urandom); bv = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      d0 = 1'($urandom); d2 = 1'($urandom); rv = 1'($urandom); clr = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_res0", res0, 0); chk("rst_rvo0", rvo0, 0); chk("rst_a0", fa0, 0);
      chk("rst_av0", fav0, 0); chk("rst_busy2", busy2, 0); chk("rst_err2", err2, 0);
      chk("rst_ovf2", ovf2, 0); chk("rst_res2", res2, 0);
    end
    av = 0; bv = 0; a = 0; b = 0; d0 = 0; d2 = 0; rv = 0; clr = 0;
    @(negedge clk) rst_n = 1'b1;
    step(1, 3, 1, 4); step(1, -2, 1, 5); step(1, 7, 1, 7);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 100);
    step(0, 0, 0, 0, 0, 0, 1, 1, 200);
    step(0, 9, 1, 3);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0);
    beats2(7, -9);
    step(1, 1, 1, 2); step(1, 3, 1, 4);
    repeat (3) step(1, 5, 1, 6, 0, 0, 0, 0, 0, 0);
    step(1, 7, 1, 8);
    step(0, 0, 0, 0, 0, 1, 1);
    beats2(11, 22);
    repeat (3) step(1, 127, 1, 127);
    step(0, 0, 0, 0, 0, 1, 1);
    beats2(1, 2);
    step(1, 2, 1, 5); step(1, 5, 1, 5, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    beats2(3, 4);
    step(1, 2, 1, 5); step(1, 2, 1, 3, 0, 1, 1);
    beats2(5, 6);
    step(0, 0, 0, 0, 0, 1, 1);
    beats2(-1, -2);
    repeat (3) step(1, -128, 1, 127);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    beats2(8, 9);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("q0_drained", q0.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
